// File: rtl/mult_8x8_seq_sched_if.sv
// rtl/mult_8x8_seq_sched_if.sv - operand, result and sub-multiplier bus for mult_8x8_seq_sched
//
// Signal groups:
//   operand stream  : in_valid, in_ready, A[7:0], B[7:0], cfg_mode[7:0]
//   sub-multiplier  : SA[3:0], SB[3:0], SMODE[1:0] to the kernel, SR[7:0] back
//   result stream   : out_valid, out_ready, R[15:0]
// Modports:
//   slave  - the scheduler
//   master - the environment (operand producer, external kernel, result consumer)
interface mult_8x8_seq_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  cfg_mode;
    logic [3:0]  SA;
    logic [3:0]  SB;
    logic [1:0]  SMODE;
    logic [7:0]  SR;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] R;

    modport slave (
        input  in_valid, A, B, cfg_mode, SR, out_ready,
        output in_ready, SA, SB, SMODE, out_valid, R
    );

    modport master (
        output in_valid, A, B, cfg_mode, SR, out_ready,
        input  in_ready, SA, SB, SMODE, out_valid, R
    );
endinterface

// File: rtl/mult_8x8_seq_sched.sv
// rtl/mult_8x8_seq_sched.sv - 8x8 multiplier built from one shared 4x4 approximate kernel over four quadrant cycles
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mult_8x8_seq_sched_if.slave:
//          operand stream (in_valid/in_ready, A, B, cfg_mode),
//          kernel drive (SA, SB, SMODE) and kernel product SR (combinational, same cycle),
//          result stream (out_valid/out_ready, R)
// Optional build macro:
//   MULT_SEQ_ZERO_SKIP_EN - skip quadrants whose A or B nibble is zero
module mult_8x8_seq_sched #(
    parameter int NIB   = 4,
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    mult_8x8_seq_sched_if.slave     bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_Q0   = 3'd1;
    localparam logic [2:0] S_Q1   = 3'd2;
    localparam logic [2:0] S_Q2   = 3'd3;
    localparam logic [2:0] S_Q3   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]         state;
    logic [2*NIB-1:0]   a_q;
    logic [2*NIB-1:0]   b_q;
    logic [7:0]         cfg_q;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   contrib;
    logic [NIB-1:0]     sa;
    logic [NIB-1:0]     sb;
    logic [1:0]         smode;
    logic [2:0]         accept_next;
    logic [2:0]         q_next;

    // Kernel operands and the shifted partial product follow directly from the state.
    always_comb begin
        sa      = '0;
        sb      = '0;
        smode   = '0;
        contrib = '0;
        case (state)
            S_Q0: begin
                sa      = a_q[NIB-1:0];
                sb      = b_q[NIB-1:0];
                smode   = cfg_q[1:0];
                contrib = ACC_W'(bus.SR);
            end
            S_Q1: begin
                sa      = a_q[NIB-1:0];
                sb      = b_q[2*NIB-1:NIB];
                smode   = cfg_q[3:2];
                contrib = ACC_W'(bus.SR) << NIB;
            end
            S_Q2: begin
                sa      = a_q[2*NIB-1:NIB];
                sb      = b_q[NIB-1:0];
                smode   = cfg_q[5:4];
                contrib = ACC_W'(bus.SR) << NIB;
            end
            S_Q3: begin
                sa      = a_q[2*NIB-1:NIB];
                sb      = b_q[2*NIB-1:NIB];
                smode   = cfg_q[7:6];
                contrib = ACC_W'(bus.SR) << (2 * NIB);
            end
            default: ;
        endcase
    end

`ifdef MULT_SEQ_ZERO_SKIP_EN
    // First quadrant at or after index 'from' whose two nibbles are both nonzero.
    // Quadrant i is state S_Q0+i, so passing the current Qn state as 'from'
    // searches from the following quadrant onwards.
    function automatic logic [2:0] skip_next(input logic [2:0] from,
                                             input logic [2*NIB-1:0] a,
                                             input logic [2*NIB-1:0] b);
        logic [3:0] live;
        live[0] = (a[NIB-1:0] != '0)     && (b[NIB-1:0] != '0);
        live[1] = (a[NIB-1:0] != '0)     && (b[2*NIB-1:NIB] != '0);
        live[2] = (a[2*NIB-1:NIB] != '0) && (b[NIB-1:0] != '0);
        live[3] = (a[2*NIB-1:NIB] != '0) && (b[2*NIB-1:NIB] != '0);
        skip_next = S_DONE;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && live[i]) begin
                skip_next = 3'(i + 1);
            end
        end
    endfunction

    assign accept_next = skip_next(3'd0, bus.A, bus.B);
    assign q_next      = skip_next(state, a_q, b_q);
`else
    assign accept_next = S_Q0;
    assign q_next      = state + 3'd1;   // S_Q3 + 1 lands on S_DONE
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cfg_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        cfg_q <= bus.cfg_mode;
                        acc   <= '0;
                        state <= accept_next;
                    end
                end
                S_Q0, S_Q1, S_Q2, S_Q3: begin
                    acc   <= acc + contrib;
                    state <= q_next;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.SA        = sa;
    assign bus.SB        = sb;
    assign bus.SMODE     = smode;
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    // R only shows the finished product; partial sums stay internal.
    assign bus.R         = (state == S_DONE) ? acc[15:0] : 16'h0000;

endmodule

// File: tb/tb_mult_8x8_seq_sched.sv
// tb/tb_mult_8x8_seq_sched.sv - directed table-driven bench for mult_8x8_seq_sched
module tb_mult_8x8_seq_sched;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    bit   stuck;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_8x8_seq_sched_if bus();

    mult_8x8_seq_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External kernel: exact 4x4 product, or a stuck-at-0xFF kernel.
    assign bus.SR = stuck ? 8'hFF : (8'(bus.SA) * 8'(bus.SB));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  cfg;
        bit          stk;
        logic [15:0] r_full;
        logic [15:0] r_skip;
        int          lat_skip;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench one cycle after the accept edge (cycle t+1).
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] cfg);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick;
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.cfg_mode = cfg;
        tick;
        bus.in_valid = 1'b0;
        // Scribble over the operands; the latched copy must be used.
        bus.A        = ~a;
        bus.B        = 8'h5A;
        bus.cfg_mode = 8'hFF;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            tick;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [15:0] r_hold;

        vecs[0] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 16'hFE01, 16'hFE01, 5};
        vecs[1] = '{8'h21, 8'h43, 8'hE4, 1'b0, 16'h08A3, 16'h08A3, 5};
        vecs[2] = '{8'h11, 8'h11, 8'h1B, 1'b1, 16'h1FDF, 16'h1FDF, 5};
        vecs[3] = '{8'h05, 8'h30, 8'h00, 1'b0, 16'h00F0, 16'h00F0, 2};
        vecs[4] = '{8'h00, 8'h77, 8'h55, 1'b0, 16'h0000, 16'h0000, 1};
        vecs[5] = '{8'h80, 8'h02, 8'h00, 1'b0, 16'h0100, 16'h0100, 2};
        vecs[6] = '{8'hF0, 8'hF0, 8'hAA, 1'b0, 16'hE100, 16'hE100, 2};
        vecs[7] = '{8'h10, 8'h01, 8'h00, 1'b1, 16'h1FDF, 16'h0FF0, 2};

        rst           = 1'b1;
        stuck         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.cfg_mode  = 8'h00;
        bus.out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;

        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_R",         32'(bus.R),         32'd0);
        chk("rst_SA_SB_SM",  32'({bus.SA, bus.SB, bus.SMODE}), 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            stuck = vecs[i].stk;
            start_op(vecs[i].a, vecs[i].b, vecs[i].cfg);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), SKIP ? 32'(vecs[i].lat_skip) : 32'd5);
            chk($sformatf("vec%0d_R", i), 32'(bus.R), SKIP ? 32'(vecs[i].r_skip) : 32'(vecs[i].r_full));
            bus.out_ready = 1'b1;
            tick;
            bus.out_ready = 1'b0;
            chk($sformatf("vec%0d_drain", i), 32'(bus.out_valid), 32'd0);
        end
        stuck = 1'b0;

        // Kernel drive sequence and in_ready low while busy.
        start_op(8'h21, 8'h43, 8'hE4);
        chk("seq_c1", 32'({bus.SA, bus.SB, bus.SMODE, bus.in_ready}), 32'({4'd1, 4'd3, 2'd0, 1'b0}));
        tick;
        chk("seq_c2", 32'({bus.SA, bus.SB, bus.SMODE, bus.in_ready}), 32'({4'd1, 4'd4, 2'd1, 1'b0}));
        tick;
        chk("seq_c3", 32'({bus.SA, bus.SB, bus.SMODE, bus.in_ready}), 32'({4'd2, 4'd3, 2'd2, 1'b0}));
        tick;
        chk("seq_c4", 32'({bus.SA, bus.SB, bus.SMODE, bus.in_ready}), 32'({4'd2, 4'd4, 2'd3, 1'b0}));
        tick;
        chk("seq_done_valid", 32'(bus.out_valid), 32'd1);
        chk("seq_done_kernel_idle", 32'({bus.SA, bus.SB, bus.SMODE, bus.in_ready}), 32'd0);

        // Backpressure: hold for 3 cycles with a new operation waiting.
        r_hold        = bus.R;
        bus.in_valid  = 1'b1;
        bus.A         = 8'h03;
        bus.B         = 8'h07;
        bus.cfg_mode  = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_R", 32'(bus.R), 32'h08A3);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("bp_R_held", 32'(bus.R), 32'(r_hold));
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_idle_ready", 32'(bus.in_ready),  32'd1);
        tick;   // held in_valid is accepted on this edge
        bus.in_valid = 1'b0;
        chk("bp_next_accepted", 32'(bus.in_ready), 32'd0);
        wait_done(lat);
        chk("bp_next_latency", 32'(lat), SKIP ? 32'd2 : 32'd5);
        chk("bp_next_R", 32'(bus.R), 32'd21);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;

        // Reset while the third quadrant is active.
        start_op(8'hFF, 8'hFF, 8'h00);
        tick;
        tick;
        chk("rq2_in_Q2", 32'({bus.SA, bus.SB}), 32'({4'hF, 4'hF}));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rq2_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rq2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rq2_R",         32'(bus.R),         32'd0);
        chk("rq2_kernel",    32'({bus.SA, bus.SB, bus.SMODE}), 32'd0);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (bus.out_valid) lat++;
        end
        chk("rq2_no_result", 32'(lat), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
